// File: rtl/fifo_umbrales.sv
// fifo_umbrales: synchronous FIFO with programmable almost-full/almost-empty
// watermarks feeding the flow-control FSM, plus a sticky overflow flag.
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   init                 loads umbral_hi/umbral_lo and clears error_full
//   umbral_hi/umbral_lo  watermark values captured while init is high
//   push, data_in        write request and data
//   pop                  read request
//   data_out, valid_out  registered read data, valid one cycle after an accepted pop
//   count                occupancy 0..2**ADDR_W
//   full, empty          occupancy decodes
//   fifo_pause           count >= high watermark
//   fifo_continue        count <= low watermark
//   error_full           sticky, set by a push into a full FIFO without pop
module fifo_umbrales #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEF_HI = 3,
  parameter int unsigned DEF_LO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   umbral_hi,
  input  logic [ADDR_W:0]   umbral_lo,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              fifo_pause,
  output logic              fifo_continue,
  output logic              error_full
);

  localparam int unsigned      DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]  HI_RST    = (ADDR_W + 1)'(DEF_HI);
  localparam logic [ADDR_W:0]  LO_RST    = (ADDR_W + 1)'(DEF_LO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   hi_q, hi_d;
  logic [ADDR_W:0]   lo_q, lo_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              error_full_q, error_full_d;

  logic push_ok;
  logic pop_ok;

  assign full          = (count_q == DEPTH_CNT);
  assign empty         = (count_q == '0);
  assign fifo_pause    = (count_q >= hi_q);
  assign fifo_continue = (count_q <= lo_q);
  assign count         = count_q;
  assign data_out      = data_out_q;
  assign valid_out     = valid_out_q;
  assign error_full    = error_full_q;

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle;
  // an empty FIFO never forwards a simultaneous push to the read side.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    error_full_d = error_full_q;

    if (init) begin
      hi_d         = umbral_hi;
      lo_d         = umbral_lo;
      error_full_d = 1'b0;
    end

    // An overflow in the init cycle itself is still reported.
    if (push && full && !pop) begin
      error_full_d = 1'b1;
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    if (pop_ok) begin
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hi_q         <= HI_RST;
      lo_q         <= LO_RST;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      error_full_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      error_full_q <= error_full_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fifo_umbrales.sv
module tb_fifo_umbrales;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              init = 1'b0;
  logic [ADDR_W:0]   umbral_hi = '0;
  logic [ADDR_W:0]   umbral_lo = '0;
  logic              push = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              fifo_pause;
  logic              fifo_continue;
  logic              error_full;

  always #5 clk = ~clk;

  fifo_umbrales #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEF_HI(3),
    .DEF_LO(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .umbral_hi(umbral_hi),
    .umbral_lo(umbral_lo),
    .push(push),
    .data_in(data_in),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .count(count),
    .full(full),
    .empty(empty),
    .fifo_pause(fifo_pause),
    .fifo_continue(fifo_continue),
    .error_full(error_full)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of words plus the watermark/flag registers.
  int mq[$];
  int m_hi = 3;
  int m_lo = 1;
  int m_dout = 0;
  int m_vout = 0;
  int m_err = 0;

  typedef struct {
    bit r; bit i; int uh; int ul; bit pu; int d; bit po;
    int cnt; int dout; int vout; int full; int empty; int pause; int cont; int err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    begin
      bit was_full;
      bit pok;
      bit wok;
      if (reset) begin
        mq.delete();
        m_hi = 3; m_lo = 1; m_dout = 0; m_vout = 0; m_err = 0;
      end else begin
        was_full = (mq.size() == DEPTH);
        pok = pop && (mq.size() > 0);
        wok = push && (!was_full || pop);
        if (init) begin
          m_hi = int'(umbral_hi);
          m_lo = int'(umbral_lo);
          m_err = 0;
        end
        if (push && was_full && !pop) m_err = 1;
        m_vout = pok ? 1 : 0;
        if (pok) m_dout = mq.pop_front();
        if (wok) mq.push_back(int'(data_in));
      end
    end
  endtask

  task automatic drive(input bit r, input bit i, input int uh, input int ul,
                       input bit pu, input int d, input bit po);
    reset     = r;
    init      = i;
    umbral_hi = 3'(uh);
    umbral_lo = 3'(ul);
    push      = pu;
    data_in   = 6'(d);
    pop       = po;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, int'(count), mq.size());
    chk({tag, "_data_out"}, int'(data_out), m_dout);
    chk({tag, "_valid_out"}, int'(valid_out), m_vout);
    chk({tag, "_full"}, int'(full), (mq.size() == DEPTH) ? 1 : 0);
    chk({tag, "_empty"}, int'(empty), (mq.size() == 0) ? 1 : 0);
    chk({tag, "_pause"}, int'(fifo_pause), (mq.size() >= m_hi) ? 1 : 0);
    chk({tag, "_continue"}, int'(fifo_continue), (mq.size() <= m_lo) ? 1 : 0);
    chk({tag, "_error_full"}, int'(error_full), m_err);
  endtask

  task automatic check_vals(input string tag, input int cnt, input int dout, input int vout,
                            input int err);
    chk({tag, "_count"}, int'(count), cnt);
    chk({tag, "_data_out"}, int'(data_out), dout);
    chk({tag, "_valid_out"}, int'(valid_out), vout);
    chk({tag, "_error_full"}, int'(error_full), err);
  endtask

  function automatic vec_t v(input bit r, input bit i, input int uh, input int ul,
                             input bit pu, input int d, input bit po,
                             input int cnt, input int dout, input int vout, input int f,
                             input int e, input int p, input int c, input int err);
    vec_t x;
    x.r = r; x.i = i; x.uh = uh; x.ul = ul; x.pu = pu; x.d = d; x.po = po;
    x.cnt = cnt; x.dout = dout; x.vout = vout; x.full = f; x.empty = e;
    x.pause = p; x.cont = c; x.err = err;
    return x;
  endfunction

  initial begin
    //                r  i uh ul pu  d     po  cnt dout  v  f  e  p  c  err
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0,  0, 0,    0, 0, 1, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0,  0, 0,    0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h11, 0,  1, 0,    0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h22, 0,  2, 0,    0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h33, 0,  3, 0,    0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  2, 'h11, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  1, 'h22, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  0, 'h33, 1, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0,  0, 'h33, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  0, 'h33, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h01, 0,  1, 'h33, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h02, 0,  2, 'h33, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h03, 0,  3, 'h33, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h04, 0,  4, 'h33, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h3F, 0,  4, 'h33, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0,  4, 'h33, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(0, 1, 3, 1, 0, 0,    0,  4, 'h33, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h05, 1,  4, 'h01, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  3, 'h02, 1, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  2, 'h03, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  1, 'h04, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  0, 'h05, 1, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 1, 2, 0, 0, 0,    0,  0, 'h05, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h0A, 0,  1, 'h05, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h0B, 0,  2, 'h05, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  1, 'h0A, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  0, 'h0B, 1, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h01, 0,  1, 'h0B, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h02, 0,  2, 'h0B, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h03, 0,  3, 'h0B, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0,  0, 0,    0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  0, 0,    0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h07, 1,  1, 0,    0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h08, 0,  2, 0,    0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 'h09, 0,  3, 0,    0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 4, 0, 0,    0,  3, 0,    0, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    1,  2, 'h07, 1, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 1, 3, 1, 1, 'h0C, 0,  3, 'h07, 0, 0, 0, 1, 0, 0));

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("row%0d", k);
      drive(vecs[k].r, vecs[k].i, vecs[k].uh, vecs[k].ul, vecs[k].pu, vecs[k].d, vecs[k].po);
      chk({tag, "_count"}, int'(count), vecs[k].cnt);
      chk({tag, "_data_out"}, int'(data_out), vecs[k].dout);
      chk({tag, "_valid_out"}, int'(valid_out), vecs[k].vout);
      chk({tag, "_full"}, int'(full), vecs[k].full);
      chk({tag, "_empty"}, int'(empty), vecs[k].empty);
      chk({tag, "_pause"}, int'(fifo_pause), vecs[k].pause);
      chk({tag, "_continue"}, int'(fifo_continue), vecs[k].cont);
      chk({tag, "_error_full"}, int'(error_full), vecs[k].err);
    end

    // Overflow flag stays set while the FIFO drains and refills.
    drive(0, 0, 0, 0, 1, 'h0D, 0);
    check_vals("seq_fill", 4, 'h07, 0, 0);
    drive(0, 0, 0, 0, 1, 'h0E, 0);
    check_vals("seq_ovf", 4, 'h07, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_vals("seq_pop1", 3, 'h08, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_vals("seq_pop2", 2, 'h09, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_vals("seq_pop3", 1, 'h0C, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_vals("seq_pop4", 0, 'h0D, 1, 1);
    drive(0, 0, 0, 0, 1, 'h10, 0);
    check_vals("seq_refill", 1, 'h0D, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_vals("seq_last", 0, 'h10, 1, 1);
    drive(0, 1, 3, 1, 0, 0, 0);
    check_vals("seq_init_clr", 0, 'h10, 0, 0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 800; n++) begin
      bit r;
      bit i;
      r = ($urandom_range(0, 79) == 0);
      i = ($urandom_range(0, 24) == 0);
      drive(r, i, $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 99) < 55), $urandom_range(0, 63),
            ($urandom_range(0, 99) < 45));
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
